instr_prefetch_buffer: RTL

- Instruction-side stage directly upstream of nanocpu: consumes the CPU's p_address and drives its p_data.
- Holds one line of LINE_WORDS consecutive instructions, fetched from a multi-cycle program memory over a req/ack handshake.
- Signals p_ready so the fetch stage can stall on a miss.
- Inserts a NOP (32'h0) whenever p_ready=0.

---
 rtl/nanocpu_pkg.sv | 18 +
 rtl/instr_prefetch_buffer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/nanocpu_pkg.sv
// Shared definitions for the nanocpu instruction path: NOP encoding,
// prefetch-buffer state encoding and line-geometry helpers.
package nanocpu_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam int          DEF_LINE_WORDS   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } pf_state_t;

   // Number of word-offset bits inside one line.
   function automatic int off_bits(input int words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/instr_prefetch_buffer.sv
// Single-line instruction prefetch buffer between nanocpu fetch and a
// multi-cycle program memory; zero-latency hits, line refill on miss.
module instr_prefetch_buffer
   import nanocpu_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic [ADDR_W-1:0] p_address,
   output logic [DATA_W-1:0] p_data,
   output logic              p_ready,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int             OFF   = off_bits(LINE_WORDS);
   localparam int             TAG_W = ADDR_W - OFF;
   localparam logic [OFF-1:0] LAST  = OFF'(LINE_WORDS - 1);

   pf_state_t          state_r;
   logic               valid_r;
   logic               discard_r;
   logic [TAG_W-1:0]   tag_r;
   logic [TAG_W-1:0]   fill_tag_r;
   logic [OFF-1:0]     cnt_r;
   logic               mem_req_r;
   logic [ADDR_W-1:0]  mem_addr_r;
   logic [CNT_W-1:0]   miss_count_r;
   logic [DATA_W-1:0]  line_r [LINE_WORDS];

   logic [TAG_W-1:0]   addr_tag_s;
   logic [OFF-1:0]     addr_off_s;
   logic               hit_s;
   logic [DATA_W-1:0]  p_data_s;

   assign addr_tag_s = p_address[ADDR_W-1:OFF];
   assign addr_off_s = p_address[OFF-1:0];
   assign hit_s      = valid_r && (tag_r == addr_tag_s) && (state_r == IDLE);

   // Hit path: instruction straight from the line, NOP otherwise.
   always_comb begin
      p_data_s = DATA_W'(NOP);
      if (hit_s) begin
         p_data_s = line_r[addr_off_s];
      end else begin
         p_data_s = DATA_W'(NOP);
      end
   end

   // Fill controller: miss detection, memory handshake, tag/valid update.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_r      <= IDLE;
         valid_r      <= 1'b0;
         discard_r    <= 1'b0;
         tag_r        <= '0;
         fill_tag_r   <= '0;
         cnt_r        <= '0;
         mem_req_r    <= 1'b0;
         mem_addr_r   <= '0;
         miss_count_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               discard_r <= 1'b0;
               if (flush) begin
                  valid_r <= 1'b0;
               end else if (!hit_s) begin
                  state_r    <= FILL;
                  fill_tag_r <= addr_tag_s;
                  cnt_r      <= '0;
                  mem_req_r  <= 1'b1;
                  mem_addr_r <= {addr_tag_s, {OFF{1'b0}}};
                  if (miss_count_r != {CNT_W{1'b1}}) begin
                     miss_count_r <= miss_count_r + CNT_W'(1);
                  end
               end
            end
            FILL: begin
               if (flush) begin
                  discard_r <= 1'b1;
               end
               if (mem_ack) begin
                  cnt_r      <= cnt_r + OFF'(1);
                  mem_addr_r <= {fill_tag_r, cnt_r + OFF'(1)};
                  if (cnt_r == LAST) begin
                     // A flush arriving with the last word still discards it.
                     mem_req_r <= 1'b0;
                     state_r   <= IDLE;
                     tag_r     <= fill_tag_r;
                     valid_r   <= !(discard_r || flush);
                     discard_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r   <= IDLE;
               valid_r   <= 1'b0;
               mem_req_r <= 1'b0;
            end
         endcase
      end
   end

   // Line storage; contents only matter once valid_r is set.
   always_ff @(posedge clock) begin
      if ((state_r == FILL) && mem_ack) begin
         line_r[cnt_r] <= mem_rdata;
      end
   end

   assign p_data     = p_data_s;
   assign p_ready    = hit_s;
   assign mem_req    = mem_req_r;
   assign mem_addr   = mem_addr_r;
   assign miss_count = miss_count_r;

endmodule
